// File: rtl/sp_bram_arb_pkg.sv
// Shared definitions for the single-port BRAM arbiter: FSM state
// encodings and a constant log2 helper used to validate index widths.
package sp_bram_arb_pkg;

  // Top-level FSM states: zero-fill sweep, then normal arbitration.
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_ARB  = 1'b1;

  // Smallest r such that 2**r >= n; evaluated at elaboration time.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sp_bram_arb_rr_arb.sv
// Generic round-robin arbiter: the search starts at the rotating pointer
// and the pointer moves to one past the winner after each grant.
module rr_arb #(
  parameter int G_NREQ = 4,
  parameter int G_IDXW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [G_NREQ-1:0] req,
  input  logic              en,
  output logic [G_NREQ-1:0] gnt,
  output logic [G_IDXW-1:0] idx,
  output logic              any
);

  logic [G_IDXW-1:0] ptr;
  logic [G_IDXW-1:0] cand;

  // Pick the first requester at or after ptr, wrapping modulo G_NREQ.
  // NOTE: every output gets a default before the search so no path through
  // the loop leaves a value held, which would infer a latch.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < G_NREQ; k++) begin
      cand = G_IDXW'((int'(ptr) + k) % G_NREQ);
      if (en && !any && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        any       = 1'b1;
      end
    end
  end

  // Rotate priority to the requester after the winner; hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= (idx == G_IDXW'(G_NREQ - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/sp_bram_inf.sv
// Inferred single-port block RAM with one-cycle read latency.
// G_MODE selects the read-during-write behaviour of the output register:
// NO_CHANGE keeps dout unchanged on writes.
module sp_bram_inf #(
  parameter int    G_ADDR  = 6,
  parameter int    G_WIDTH = 16,
  parameter string G_MODE  = "NO_CHANGE"
) (
  input  logic               clk,
  input  logic               en,
  input  logic               we,
  input  logic [G_ADDR-1:0]  addr,
  input  logic [G_WIDTH-1:0] din,
  output logic [G_WIDTH-1:0] dout
);

  logic [G_WIDTH-1:0] mem [2**G_ADDR];

  // Synchronous write and registered read of the RAM array.
  // NOTE: the array and its output register carry no reset so the tools can
  // map them onto a block RAM; contents are defined by the zero-fill sweep.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
        if (G_MODE == "WRITE_FIRST") dout <= din;
        else if (G_MODE == "READ_FIRST") dout <= mem[addr];
      end else begin
        dout <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sp_bram_arb.sv
// Round-robin arbiter owning one single-port block RAM shared by G_NREQ
// requesters. After reset or clr the RAM is swept to zero, then one read
// or write is granted per cycle and read data is tagged back to its issuer.
module sp_bram_arb
  import sp_bram_arb_pkg::*;
#(
  parameter int G_NREQ  = 4,
  parameter int G_ADDR  = 6,
  parameter int G_WIDTH = 16,
  parameter int G_IDXW  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic [G_NREQ-1:0]         req,
  input  logic [G_NREQ-1:0]         we,
  input  logic [G_NREQ*G_ADDR-1:0]  addr,
  input  logic [G_NREQ*G_WIDTH-1:0] din,
  output logic [G_NREQ-1:0]         gnt,
  output logic [G_NREQ-1:0]         rvld,
  output logic [G_WIDTH-1:0]        rdata,
  output logic                      init_done
);

  localparam logic [G_ADDR-1:0] CNT_LAST = '1;

  if (G_IDXW != clog2(G_NREQ)) begin : g_idxw_check
    $error("sp_bram_arb: G_IDXW must equal clog2(G_NREQ)");
  end

  logic [0:0]         state;
  logic [G_ADDR-1:0]  cnt;
  logic [G_ADDR-1:0]  last_addr;
  logic               arb_en;
  logic               gnt_any;
  logic [G_IDXW-1:0]  gnt_idx;
  logic               rd_vld;
  logic [G_IDXW-1:0]  rd_idx;
  logic               ram_en;
  logic               ram_we;
  logic [G_ADDR-1:0]  ram_addr;
  logic [G_WIDTH-1:0] ram_din;

  // clr takes priority over any grant in the cycle it is high.
  assign arb_en    = (state == ST_ARB) && !clr;
  assign init_done = (state == ST_ARB);

  rr_arb #(
    .G_NREQ(G_NREQ),
    .G_IDXW(G_IDXW)
  ) u_rr_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .en   (arb_en),
    .gnt  (gnt),
    .idx  (gnt_idx),
    .any  (gnt_any)
  );

  // Zero-fill sweep counter and INIT/ARB sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      if (clr) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_LAST) state <= ST_ARB;
      end
    end else if (clr) begin
      state <= ST_INIT;
      cnt   <= '0;
    end
  end

  // Drive the RAM port from the sweep, the granted requester, or idle.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = last_addr;
    ram_din  = '0;
    if (state == ST_INIT) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = cnt;
    end else if (gnt_any) begin
      ram_en   = 1'b1;
      ram_we   = we[gnt_idx];
      ram_addr = addr[gnt_idx*G_ADDR +: G_ADDR];
      ram_din  = din[gnt_idx*G_WIDTH +: G_WIDTH];
    end
  end

  // Remember the port address for idle cycles and tag accepted reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr <= '0;
      rd_vld    <= 1'b0;
      rd_idx    <= '0;
    end else begin
      last_addr <= ram_addr;
      rd_vld    <= gnt_any && !we[gnt_idx];
      if (gnt_any) rd_idx <= gnt_idx;
    end
  end

  // Expand the registered read tag into the one-hot valid vector.
  always_comb begin
    rvld = '0;
    if (rd_vld) rvld[rd_idx] = 1'b1;
  end

  sp_bram_inf #(
    .G_ADDR (G_ADDR),
    .G_WIDTH(G_WIDTH),
    .G_MODE ("NO_CHANGE")
  ) u_ram (
    .clk (clk),
    .en  (ram_en),
    .we  (ram_we),
    .addr(ram_addr),
    .din (ram_din),
    .dout(rdata)
  );

endmodule

// File: tb/tb_sp_bram_arb.sv
// Self-checking bench for sp_bram_arb (4 requesters, 16 x 16-bit RAM).
// A negedge monitor keeps a reference model of the sweep, the round-robin
// pointer and the RAM contents, pushes expected read returns into a queue
// and pops them when rvld is due.
module tb_sp_bram_arb;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 16;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr   = 1'b0;
  logic [N-1:0]    req   = '0;
  logic [N-1:0]    we    = '0;
  logic [N*AW-1:0] addr  = '0;
  logic [N*DW-1:0] din   = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvld;
  logic [DW-1:0]   rdata;
  logic            init_done;

  sp_bram_arb #(
    .G_NREQ (N),
    .G_ADDR (AW),
    .G_WIDTH(DW),
    .G_IDXW (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .din      (din),
    .gnt      (gnt),
    .rvld     (rvld),
    .rdata    (rdata),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  tag;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [N-1:0]  gnt_log[$];
  logic [DW-1:0] mem_mdl [2**AW];
  int            n_total = 0;
  int            n_bad   = 0;
  bit            mdl_init = 1'b1;
  int            mdl_cnt  = 0;
  int            mdl_ptr  = 0;
  int            rvld_cnt = 0;
  logic [N-1:0]  last_tag   = '0;
  logic [DW-1:0] last_rdata = '0;
  exp_t          e;
  logic [N-1:0]  eg;
  int            gi;
  logic [AW-1:0] ma;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_init = 1'b1;
      mdl_cnt  = 0;
      mdl_ptr  = 0;
      sb.delete();
    end else begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rvld", rvld, e.tag);
        check("rdata", rdata, e.data);
      end else begin
        check("rvld_idle", rvld, 0);
      end
      if (rvld != 0) begin
        rvld_cnt++;
        last_tag   = rvld;
        last_rdata = rdata;
      end
      check("init_done", init_done, !mdl_init);
      eg = '0;
      gi = -1;
      if (!mdl_init && !clr)
        for (int k = 0; k < N; k++)
          if (gi < 0 && req[(mdl_ptr + k) % N]) gi = (mdl_ptr + k) % N;
      if (gi >= 0) eg[gi] = 1'b1;
      check("gnt", gnt, eg);
      if (gi >= 0) begin
        gnt_log.push_back(eg);
        ma = addr[gi*AW +: AW];
        if (we[gi]) mem_mdl[ma] = din[gi*DW +: DW];
        else sb.push_back('{tag: eg, data: mem_mdl[ma]});
        mdl_ptr = (gi + 1) % N;
      end
      if (mdl_init) begin
        mem_mdl[mdl_cnt] = '0;
        if (clr) begin
          mdl_cnt = 0;
        end else begin
          if (mdl_cnt == 2**AW - 1) mdl_init = 1'b0;
          mdl_cnt = (mdl_cnt + 1) % (2**AW);
        end
      end else if (clr) begin
        mdl_init = 1'b1;
        mdl_cnt  = 0;
      end
    end
  end

  // Raise one request, hold it until granted, then drop it after the edge.
  task automatic drive_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output int waited);
    bit ok;
    ok     = 1'b0;
    waited = 0;
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*AW +: AW] = a;
    din[i*DW +: DW]  = d;
    while (!ok && waited < 64) begin
      @(negedge clk);
      if (gnt[i] === 1'b1) ok = 1'b1;
      else waited++;
    end
    check($sformatf("grant_wait_r%0d", i), ok, 1);
    @(posedge clk);
    #1;
    req[i] = 1'b0;
  endtask

  task automatic two_reads(input int i);
    int w;
    drive_req(i, 1'b0, AW'(i), '0, w);
    drive_req(i, 1'b0, AW'(i + 4), '0, w);
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c2, w, w1, w2, w3;
    logic [N-1:0] exp_seq [8];
    for (int k = 0; k < 8; k++) exp_seq[k] = N'(1 << (k % N));

    // Reset state, with every requester asserting.
    req = '1;
    #3;
    check("rst_gnt", gnt, 0);
    check("rst_rvld", rvld, 0);
    check("rst_init_done", init_done, 0);
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Sweep length, no grants during INIT, then round-robin order from ptr 0.
    gnt_log.delete();
    fork
      begin
        c = 0;
        while (!init_done && c < 100) begin
          check("gnt_in_init", gnt, 0);
          @(posedge clk);
          #1;
          c++;
        end
        check("init_cycles", c, 16);
      end
      two_reads(0);
      two_reads(1);
      two_reads(2);
      two_reads(3);
    join
    check("gnt_seq_len", gnt_log.size(), 8);
    for (int k = 0; k < 8 && k < gnt_log.size(); k++)
      check($sformatf("gnt_seq_%0d", k), gnt_log[k], exp_seq[k]);
    settle();

    // Every address reads back zero after the sweep.
    for (int a = 0; a < 2**AW; a++) drive_req(0, 1'b0, AW'(a), '0, w);
    settle();
    check("sweep_last_data", last_rdata, 16'h0000);

    // Write then read of the same address on consecutive grants.
    drive_req(2, 1'b1, 4'd5, 16'hBEEF, w);
    drive_req(0, 1'b0, 4'd5, '0, w);
    check("raw_wait", w, 0);
    settle();
    check("raw_tag", last_tag, 4'b0001);
    check("raw_data", last_rdata, 16'hBEEF);

    // Continuous writer against a reader: bounded wait, one rvld only.
    c = rvld_cnt;
    fork
      begin
        for (int k = 0; k < 5; k++) drive_req(1, 1'b1, 4'd3, 16'h1234, w1);
      end
      begin
        @(posedge clk);
        #1;
        drive_req(3, 1'b0, 4'd3, '0, w3);
      end
    join
    settle();
    check("r3_wait_lt2", (w3 < 2), 1);
    check("r3_tag", last_tag, 4'b1000);
    check("r3_data", last_rdata, 16'h1234);
    check("contend_rvld_cnt", rvld_cnt - c, 1);

    // Read accepted, then clr: the read still returns, then a full sweep.
    c = rvld_cnt;
    drive_req(0, 1'b0, 4'd3, '0, w);
    clr = 1'b1;
    fork
      drive_req(2, 1'b0, 4'd3, '0, w2);
      begin
        #2;
        check("gnt_during_clr", gnt, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_init_drop", init_done, 0);
        c2 = 0;
        while (!init_done && c2 < 100) begin
          @(posedge clk);
          #1;
          c2++;
        end
        check("clr_init_cycles", c2, 16);
      end
    join
    settle();
    check("clr_rvld_cnt", rvld_cnt - c, 2);
    check("post_clr_tag", last_tag, 4'b0100);
    check("post_clr_data", last_rdata, 16'h0000);

    // Async reset while a read return is on the outputs.
    req[0] = 1'b1;
    we[0]  = 1'b0;
    addr[0*AW +: AW] = 4'd7;
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    req[1] = 1'b1;
    we[1]  = 1'b0;
    addr[1*AW +: AW] = 4'd8;
    @(negedge clk);
    #2;
    check("pre_rst_rvld", rvld, 4'b0001);
    check("pre_rst_gnt", gnt, 4'b0010);
    rst_n = 1'b0;
    #1;
    check("async_rst_rvld", rvld, 0);
    check("async_rst_gnt", gnt, 0);
    check("async_rst_init_done", init_done, 0);
    req = '0;
    c = rvld_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    c2 = 0;
    while (!init_done && c2 < 100) begin
      @(posedge clk);
      #1;
      c2++;
    end
    check("rst_init_cycles", c2, 16);
    check("rst_no_rvld", rvld_cnt, c);

    // Contents are back to zero after the repeated sweep.
    drive_req(1, 1'b0, 4'd7, '0, w);
    settle();
    check("final_tag", last_tag, 4'b0010);
    check("final_data", last_rdata, 16'h0000);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sp_bram_arb.md
Name: sp_bram_arb

Overview:
Round-robin arbiter that shares one single-port block RAM (sp_bram_inf, G_MODE "NO_CHANGE") between G_NREQ requesters.
- Owns the RAM port.
- Clears the full RAM to zero after reset or on request.
- Grants one read or write per cycle.
- Routes one-cycle-latency read data back to the issuing requester.
- Sits between client engines and the shared table/buffer RAM.

Parameters:
G_NREQ, 4, number of requesters (2..8)
G_ADDR, 6, RAM address width
G_WIDTH, 16, RAM data width
G_IDXW, 2, requester index width, must equal ceil(log2(G_NREQ))

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  pulse: re-run zero-fill of whole RAM
req  input  G_NREQ  per-requester access request, held until granted
we  input  G_NREQ  per-requester write enable (1 write, 0 read)
addr  input  G_NREQ*G_ADDR  flattened addresses, requester i at [i*G_ADDR +: G_ADDR]
din  input  G_NREQ*G_WIDTH  flattened write data, same packing
gnt  output  G_NREQ  one-hot combinational grant; req[i]&gnt[i] = accepted this cycle
rvld  output  G_NREQ  one-hot registered read-data valid
rdata  output  G_WIDTH  shared read data, valid when any rvld bit set
init_done  output  1  high when RAM clear complete and arbitration enabled

Behaviour:
- Reset (rst_n low, async) sets:
  - state INIT, init counter 0, rr pointer 0
  - rvld 0, init_done 0, in-flight read tag cleared
  - gnt 0, since it is forced low in INIT
- FSM states are INIT and ARB:
  - INIT: drive RAM we=1, addr=counter, din=0. Counter increments each cycle.
  - INIT: at counter = 2^G_ADDR-1, the write occurs, the counter wraps to 0 and the FSM goes to ARB next cycle. Full clear takes 2^G_ADDR cycles.
  - ARB: init_done=1 and arbitration is active.
  - clr in ARB: go to INIT next cycle. No grant in the cycle clr is high (clr has priority).
  - clr in INIT: counter restarts at 0 next cycle.
- Arbitration (ARB, clr low):
  - Search starts at index ptr and wraps modulo G_NREQ. The first i with req[i]=1 gets gnt[i]=1, and only that bit is set.
  - On a grant, ptr becomes (i+1) mod G_NREQ. With no request, ptr holds.
  - RAM port is driven from the granted requester's we/addr/din. With no grant, RAM we=0 and addr holds its last value.
  - Requests are never dropped: an ungranted requester keeps req high, and the block does not require addr/din to be stable.
- Read return:
  - Accepted read at cycle N gives rvld[i]=1 with rdata = mem[addr] at cycle N+1, for exactly one cycle.
  - Accepted write gives no rvld. The RAM output holds (NO_CHANGE), so rdata is don't-care when rvld=0.
  - Back-to-back reads from different requesters give consecutive rvld pulses with the correct one-hot tag.
  - A read accepted in the cycle before ARB→INIT still returns rvld at N+1 (pipeline drains).
- Read-after-write to the same address on consecutive grants returns the new data.
- Throughput is 1 access per cycle sustained. Starvation bound is G_NREQ-1 cycles of waiting once req is high.
- Async reset mid-operation: in-flight read is discarded (no rvld), RAM contents are undefined until INIT completes.
- gnt depends combinationally on req/state/clr. A requester must not make req depend combinationally on gnt.

Decomposition:
- Shared include: state encodings (ST_INIT, ST_ARB) and a clog2 constant function for G_IDXW checking.
- One sub-module, rr_arb: a generic G_NREQ round-robin arbiter.
  - Inputs: req, en, ptr.
  - Outputs: gnt one-hot, idx.
  - Also updates ptr.
- Top-level contents:
  - FSM
  - init counter
  - mux onto the RAM port
  - registered read tag (valid + idx) to generate rvld
  - sp_bram_inf instance

Test Plan (G_NREQ=4, G_ADDR=4, G_WIDTH=16):
- Reset release → init_done goes high at cycle 16 after reset. A read of every address 0..15 returns 0x0000. gnt stays 0 during INIT even with req=4'b1111.
- req=4'b1111 held, all reads, ptr=0 → gnt sequence 0001,0010,0100,1000,0001. rvld follows one cycle later with the same one-hot tag.
- Requester 2 writes 0xBEEF to addr 5; requester 0 reads addr 5 on the next grant → rvld=4'b0001, rdata=0xBEEF.
- Requester 1 continuously writes 0x1234 to addr 3 while requester 3 reads addr 3 → requester 3 is granted within 2 cycles, rvld[3] with 0x1234, and no rvld for the writes.
- Read accepted, then clr pulsed the next cycle → rvld still delivered. init_done drops, 16 clear cycles follow, then addr 3 reads 0x0000. No gnt while clr is high.
- rst_n asserted mid-read, asynchronously between clock edges → rvld, gnt and init_done go 0 immediately. After release the INIT sweep repeats in full (16 cycles).
